counter_wrap_monitor: RTL and testbench

//   Downstream consumer of the 4-bit up/down counter. Samples the counter output each cycle.

---
 rtl/counter_wrap_monitor.sv | 104 ++++++++++
 tb/tb_counter_wrap_monitor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_wrap_monitor.sv
// Monitors a WIDTH-bit up/down counter for wrap events and illegal steps, with a latched FAULT state.
// Optional define COUNTER_WRAP_MON_DIRCHK_EN also flags +1/-1 steps that disagree with the direction.
module counter_wrap_monitor #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned WRAP_CNT_W = 8,
  parameter int unsigned ERR_LIMIT  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      cnt_in,
  input  logic                  up,
  input  logic                  clr,
  output logic                  wrap_pulse,
  output logic                  wrap_dir,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic                  step_err,
  output logic [3:0]            err_count,
  output logic                  fault
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [3:0]       ERR_LIM = 4'(ERR_LIMIT);

  logic [1:0]       state;
  logic [WIDTH-1:0] prev;
  logic             up_d;

  logic [WIDTH-1:0] prev_inc;
  logic [WIDTH-1:0] prev_dec;
  logic             is_hold;
  logic             is_wrap_up;
  logic             is_wrap_dn;
  logic             is_step;
  logic             step_bad;
  logic             is_err;

  always_comb begin
    prev_inc   = prev + WIDTH'(1);
    prev_dec   = prev - WIDTH'(1);
    is_hold    = (cnt_in == prev);
    is_wrap_up = (prev == CNT_MAX) && (cnt_in == '0) && up_d;
    is_wrap_dn = (prev == '0) && (cnt_in == CNT_MAX) && !up_d;
    is_step    = (cnt_in == prev_inc) || (cnt_in == prev_dec);
`ifdef COUNTER_WRAP_MON_DIRCHK_EN
    step_bad   = ((cnt_in == prev_inc) && !up_d) || ((cnt_in == prev_dec) && up_d);
`else
    step_bad   = 1'b0;
`endif
    // Unit steps take precedence over the "jump to zero" counter-reset rule.
    is_err     = !is_hold && !is_wrap_up && !is_wrap_dn &&
                 (is_step ? step_bad : (cnt_in != '0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      prev       <= '0;
      up_d       <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_dir   <= 1'b0;
      wrap_count <= '0;
      step_err   <= 1'b0;
      err_count  <= '0;
      fault      <= 1'b0;
    end else begin
      prev       <= cnt_in;
      up_d       <= up;
      wrap_pulse <= 1'b0;
      step_err   <= 1'b0;
      if (clr) begin
        state      <= ST_IDLE;
        wrap_dir   <= 1'b0;
        wrap_count <= '0;
        err_count  <= '0;
        fault      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_TRACK;
          ST_TRACK: begin
            if (is_wrap_up || is_wrap_dn) begin
              wrap_pulse <= 1'b1;
              wrap_dir   <= is_wrap_up;
              if (wrap_count != '1) wrap_count <= wrap_count + WRAP_CNT_W'(1);
            end else if (is_err) begin
              step_err <= 1'b1;
              if (err_count != ERR_LIM) err_count <= err_count + 4'd1;
              if (err_count + 4'd1 >= ERR_LIM) begin
                state <= ST_FAULT;
                fault <= 1'b1;
              end
            end
          end
          ST_FAULT: state <= ST_FAULT;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Scoreboard bench for counter_wrap_monitor: driver pushes model predictions, monitor pops and compares.
module tb_counter_wrap_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cnt_in = '0;
  logic       up = 1'b0;
  logic       clr = 1'b0;
  logic       wrap_pulse;
  logic       wrap_dir;
  logic [7:0] wrap_count;
  logic       step_err;
  logic [3:0] err_count;
  logic       fault;

  counter_wrap_monitor #(.WIDTH(4), .WRAP_CNT_W(8), .ERR_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .up(up), .clr(clr),
    .wrap_pulse(wrap_pulse), .wrap_dir(wrap_dir), .wrap_count(wrap_count),
    .step_err(step_err), .err_count(err_count), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wp; int wd; int wc; int se; int ec; int f;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: "armed" means a previous sample exists and checking is live.
  bit m_armed, m_faulted, m_dir, m_upd;
  int m_prev, m_wraps, m_errs;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_faulted = 0; m_dir = 0; m_upd = 0;
    m_prev = 0; m_wraps = 0; m_errs = 0;
  endtask

  task automatic drive(input int cnt, input bit u, input bit c);
    exp_t e;
    int d;
    bit wrap, err;
    @(negedge clk);
    cnt_in = 4'(cnt); up = u; clr = c;
    wrap = 0; err = 0;
    if (c) begin
      m_wraps = 0; m_errs = 0; m_dir = 0; m_faulted = 0; m_armed = 0;
    end else if (!m_armed) begin
      m_armed = 1;
    end else if (!m_faulted) begin
      d = (cnt - m_prev + 16) % 16;
      if (d == 0) begin
      end else if (m_prev == 15 && cnt == 0 && m_upd) begin
        wrap = 1; m_dir = 1;
      end else if (m_prev == 0 && cnt == 15 && !m_upd) begin
        wrap = 1; m_dir = 0;
      end else if (d == 1 || d == 15) begin
`ifdef COUNTER_WRAP_MON_DIRCHK_EN
        if ((d == 1 && !m_upd) || (d == 15 && m_upd)) err = 1;
`endif
      end else if (cnt != 0) begin
        err = 1;
      end
      if (wrap && m_wraps < 255) m_wraps++;
      if (err) begin
        m_errs++;
        if (m_errs >= 3) m_faulted = 1;
      end
    end
    m_prev = cnt; m_upd = u;
    e.wp = int'(wrap); e.se = int'(err); e.wd = int'(m_dir);
    e.wc = m_wraps; e.ec = m_errs; e.f = int'(m_faulted);
    q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wrap_pulse"}, int'(wrap_pulse), 0);
    check({tag, "_wrap_dir"},   int'(wrap_dir), 0);
    check({tag, "_wrap_count"}, int'(wrap_count), 0);
    check({tag, "_step_err"},   int'(step_err), 0);
    check({tag, "_err_count"},  int'(err_count), 0);
    check({tag, "_fault"},      int'(fault), 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("wrap_pulse", int'(wrap_pulse), e.wp);
        check("wrap_dir",   int'(wrap_dir),   e.wd);
        check("wrap_count", int'(wrap_count), e.wc);
        check("step_err",   int'(step_err),   e.se);
        check("err_count",  int'(err_count),  e.ec);
        check("fault",      int'(fault),      e.f);
      end
    end
  end

  initial begin : stim
    int g_cur, cnt, r;
    bit g_up, nu, c;
    model_reset();

    // Reset held for 20ns with a static zero count
    #19;
    check_zero("reset");
    #1 reset = 1'b1;
    drive(0, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);

    // Up wrap
    drive(13, 1, 1);
    drive(14, 1, 0);
    drive(15, 1, 0);
    drive(0, 1, 0);
    drive(1, 1, 0);
    settle();
    check("t2_wrap_count", int'(wrap_count), 1);
    check("t2_wrap_dir", int'(wrap_dir), 1);

    // Down wrap
    drive(2, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(15, 0, 0);
    drive(14, 0, 0);
    settle();
    check("t3_wrap_count", int'(wrap_count), 2);
    check("t3_wrap_dir", int'(wrap_dir), 0);
    check("t3_err_count", int'(err_count), 0);

    // Counter resets are legal; three bad jumps latch FAULT
    drive(0, 1, 0);
    for (int i = 1; i <= 7; i++) drive(i, 1, 0);
    drive(0, 1, 0);
    for (int i = 1; i <= 3; i++) drive(i, 1, 0);
    drive(9, 1, 0);
    drive(2, 1, 0);
    drive(12, 1, 0);
    drive(15, 1, 0);
    drive(0, 1, 0);
    settle();
    check("t4_err_count", int'(err_count), 3);
    check("t4_fault", int'(fault), 1);
    check("t4_wrap_count", int'(wrap_count), 2);

    // Clear out of FAULT; first sample after clear is unchecked
    drive(5, 1, 1);
    settle();
    check_zero("t5_clr");
    drive(9, 1, 0);
    drive(10, 1, 0);
    drive(12, 1, 0);
    settle();
    check("t5_err_resume", int'(err_count), 1);

    // Direction check on a +1 step while counting down
    drive(4, 0, 1);
    drive(4, 0, 0);
    drive(5, 0, 0);
    settle();
`ifdef COUNTER_WRAP_MON_DIRCHK_EN
    check("t6_dirchk_err", int'(err_count), 1);
`else
    check("t6_dirchk_err", int'(err_count), 0);
`endif

    // Wrap counter saturation: alternate up/down wraps on every edge
    drive(0, 1, 1);
    drive(15, 1, 0);
    for (int i = 0; i < 130; i++) begin
      drive(0, 0, 0);
      drive(15, 1, 0);
    end
    settle();
    check("sat_wrap_count", int'(wrap_count), 255);

    // Randomized counter-like traffic with occasional jumps, clears and one async reset
    drive(0, 1, 1);
    g_cur = 0; g_up = 1;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        @(negedge clk);
        reset = 1'b0;
        #2;
        check_zero("midreset");
        model_reset();
        q.delete();
        #1 reset = 1'b1;
      end
      r = int'($urandom_range(0, 99));
      c = (r < 4);
      if (r < 10)      cnt = int'($urandom_range(0, 15));
      else if (r < 13) cnt = 0;
      else if (r < 30) cnt = g_cur;
      else             cnt = g_up ? (g_cur + 1) % 16 : (g_cur + 15) % 16;
      nu = ($urandom_range(0, 9) == 0) ? !g_up : g_up;
      drive(cnt, nu, c);
      g_cur = cnt; g_up = nu;
    end

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
